// File: rtl/obi_host_arbiter_pkg.sv
// Shared definitions for the OBI host arbiter slice: host-ID encoding and default widths.
package obi_host_arbiter_pkg;

  localparam logic HOST_I = 1'b0;
  localparam logic HOST_D = 1'b1;

  localparam int ID_W          = 1;
  localparam int DEF_ADDR_W    = 64;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_MAX_OUTST = 2;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of host IDs for accepted-but-unanswered OBI transactions.
module obi_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  // Pointers wrap explicitly so non-power-of-two depths would also behave.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (doPush) wptr_d = nextPtr(wptr_q);
    if (doPop)  rptr_d = nextPtr(rptr_q);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (doPush) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/obi_host_arbiter.sv
// 2:1 OBI host arbiter: muxes two host address phases onto one device port and routes
// in-order responses back through an ID FIFO.
module obi_host_arbiter
  import obi_host_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_OUTST   = DEF_MAX_OUTST,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                h0_req_i,
  input  logic                h0_we_i,
  input  logic [DATA_W/8-1:0] h0_be_i,
  input  logic [ADDR_W-1:0]   h0_addr_i,
  input  logic [DATA_W-1:0]   h0_wdata_i,
  output logic                h0_gnt_o,
  output logic                h0_rvalid_o,
  output logic [DATA_W-1:0]   h0_rdata_o,
  input  logic                h1_req_i,
  input  logic                h1_we_i,
  input  logic [DATA_W/8-1:0] h1_be_i,
  input  logic [ADDR_W-1:0]   h1_addr_i,
  input  logic [DATA_W-1:0]   h1_wdata_i,
  output logic                h1_gnt_o,
  output logic                h1_rvalid_o,
  output logic [DATA_W-1:0]   h1_rdata_o,
  output logic                req_o,
  output logic                we_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic                gnt_i,
  input  logic                rvalid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic                err_o
);

  logic sel;
  logic hselReq;
  logic accept;
  logic fifoFull, fifoEmpty, fifoHead, fifoPop;
  logic lock_q, lock_d;
  logic lockId_q, lockId_d;
  logic rrPtr_q, rrPtr_d;
  logic err_q, err_d;

  // A pending (locked) request owns the port until granted so its fields stay stable.
  always_comb begin
    sel = HOST_I;
    if (lock_q)                     sel = lockId_q;
    else if (h0_req_i && !h1_req_i) sel = HOST_I;
    else if (h1_req_i && !h0_req_i) sel = HOST_D;
    else if (h0_req_i && h1_req_i)  sel = (ROUND_ROBIN != 0) ? rrPtr_q : HOST_I;
  end

  assign hselReq = (sel == HOST_D) ? h1_req_i : h0_req_i;
  assign req_o   = hselReq && !fifoFull && !rst_i;
  assign accept  = req_o && gnt_i;
  assign we_o    = (sel == HOST_D) ? h1_we_i    : h0_we_i;
  assign be_o    = (sel == HOST_D) ? h1_be_i    : h0_be_i;
  assign addr_o  = (sel == HOST_D) ? h1_addr_i  : h0_addr_i;
  assign wdata_o = (sel == HOST_D) ? h1_wdata_i : h0_wdata_i;

  assign h0_gnt_o = accept && (sel == HOST_I);
  assign h1_gnt_o = accept && (sel == HOST_D);

  assign fifoPop     = rvalid_i && !fifoEmpty;
  assign h0_rvalid_o = fifoPop && (fifoHead == HOST_I) && !rst_i;
  assign h1_rvalid_o = fifoPop && (fifoHead == HOST_D) && !rst_i;
  assign h0_rdata_o  = rdata_i;
  assign h1_rdata_o  = rdata_i;
  assign err_o       = err_q;

  obi_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (fifoPop),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (fifoHead)
  );

  // A response with nothing outstanding is a protocol violation and stays flagged.
  always_comb begin
    lock_d   = lock_q;
    lockId_d = lockId_q;
    rrPtr_d  = rrPtr_q;
    err_d    = err_q || (rvalid_i && fifoEmpty);
    if (accept) begin
      lock_d = 1'b0;
      if (ROUND_ROBIN != 0) rrPtr_d = ~sel;
    end else if (req_o) begin
      lock_d   = 1'b1;
      lockId_d = sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q   <= 1'b0;
      lockId_q <= HOST_I;
      rrPtr_q  <= HOST_I;
      err_q    <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      lockId_q <= lockId_d;
      rrPtr_q  <= rrPtr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_host_arbiter.sv
// Directed bench for obi_host_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_obi_host_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic h0Req = 0, h0We = 0, h1Req = 0, h1We = 0;
  logic [DATA_W/8-1:0] h0Be = '0, h1Be = '0;
  logic [ADDR_W-1:0] h0Addr = '0, h1Addr = '0;
  logic [DATA_W-1:0] h0Wdata = '0, h1Wdata = '0;
  logic gnt = 0, rvalid = 0;
  logic [DATA_W-1:0] rdata = '0;

  logic rrH0Gnt, rrH0Rvalid, rrH1Gnt, rrH1Rvalid, rrReq, rrWe, rrErr;
  logic [DATA_W-1:0] rrH0Rdata, rrH1Rdata, rrWdata;
  logic [DATA_W/8-1:0] rrBe;
  logic [ADDR_W-1:0] rrAddr;
  logic fxH0Gnt, fxH0Rvalid, fxH1Gnt, fxH1Rvalid, fxReq, fxWe, fxErr;
  logic [DATA_W-1:0] fxH0Rdata, fxH1Rdata, fxWdata;
  logic [DATA_W/8-1:0] fxBe;
  logic [ADDR_W-1:0] fxAddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_host_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(2), .ROUND_ROBIN(1)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0Req), .h0_we_i(h0We), .h0_be_i(h0Be), .h0_addr_i(h0Addr), .h0_wdata_i(h0Wdata),
    .h0_gnt_o(rrH0Gnt), .h0_rvalid_o(rrH0Rvalid), .h0_rdata_o(rrH0Rdata),
    .h1_req_i(h1Req), .h1_we_i(h1We), .h1_be_i(h1Be), .h1_addr_i(h1Addr), .h1_wdata_i(h1Wdata),
    .h1_gnt_o(rrH1Gnt), .h1_rvalid_o(rrH1Rvalid), .h1_rdata_o(rrH1Rdata),
    .req_o(rrReq), .we_o(rrWe), .be_o(rrBe), .addr_o(rrAddr), .wdata_o(rrWdata),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .err_o(rrErr)
  );

  obi_host_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(2), .ROUND_ROBIN(0)) u_fx (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0Req), .h0_we_i(h0We), .h0_be_i(h0Be), .h0_addr_i(h0Addr), .h0_wdata_i(h0Wdata),
    .h0_gnt_o(fxH0Gnt), .h0_rvalid_o(fxH0Rvalid), .h0_rdata_o(fxH0Rdata),
    .h1_req_i(h1Req), .h1_we_i(h1We), .h1_be_i(h1Be), .h1_addr_i(h1Addr), .h1_wdata_i(h1Wdata),
    .h1_gnt_o(fxH1Gnt), .h1_rvalid_o(fxH1Rvalid), .h1_rdata_o(fxH1Rdata),
    .req_o(fxReq), .we_o(fxWe), .be_o(fxBe), .addr_o(fxAddr), .wdata_o(fxWdata),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .err_o(fxErr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic g, input logic rv);
    h0Req  = r0;
    h1Req  = r1;
    gnt    = g;
    rvalid = rv;
    #2;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    h0Addr = 64'h1000;
    h1Addr = 64'h2000;
    h0Be   = 8'hFF;
    h1Be   = 8'h0F;

    // Reset state
    #3;
    checkOutput("rst_req", rrReq, 0);
    checkOutput("rst_err", rrErr, 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_req", rrReq, 0);
    checkOutput("idle_h0_gnt", rrH0Gnt, 0);

    // Single h0 read with zero-latency grant and next-cycle response
    applyStimulus(1, 0, 1, 0);
    checkOutput("t1_h0_gnt", rrH0Gnt, 1);
    checkOutput("t1_h1_gnt", rrH1Gnt, 0);
    checkOutput("t1_addr", rrAddr, 64'h1000);
    checkOutput("t1_be", rrBe, 8'hFF);
    nextCycle();
    rdata = 64'hAB;
    applyStimulus(0, 0, 0, 1);
    checkOutput("t1_h0_rvalid", rrH0Rvalid, 1);
    checkOutput("t1_h1_rvalid", rrH1Rvalid, 0);
    checkOutput("t1_h0_rdata", rrH0Rdata, 64'hAB);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_err", rrErr, 0);

    // Both hosts request every cycle: RR alternates, fixed always picks h0
    doReset();
    applyStimulus(1, 1, 1, 0);
    checkOutput("t2a_rr_h0_gnt", rrH0Gnt, 1);
    checkOutput("t2a_rr_h1_gnt", rrH1Gnt, 0);
    checkOutput("t2a_fx_h0_gnt", fxH0Gnt, 1);
    nextCycle();
    applyStimulus(1, 1, 1, 1);
    checkOutput("t2b_rr_h1_gnt", rrH1Gnt, 1);
    checkOutput("t2b_rr_addr", rrAddr, 64'h2000);
    checkOutput("t2b_rr_h0_rvalid", rrH0Rvalid, 1);
    checkOutput("t2b_fx_h0_gnt", fxH0Gnt, 1);
    checkOutput("t2b_fx_h1_gnt", fxH1Gnt, 0);
    nextCycle();
    applyStimulus(1, 1, 1, 1);
    checkOutput("t2c_rr_h0_gnt", rrH0Gnt, 1);
    checkOutput("t2c_rr_h1_rvalid", rrH1Rvalid, 1);
    checkOutput("t2c_fx_h0_gnt", fxH0Gnt, 1);
    nextCycle();
    applyStimulus(1, 1, 1, 1);
    checkOutput("t2d_rr_h1_gnt", rrH1Gnt, 1);
    checkOutput("t2d_rr_h0_rvalid", rrH0Rvalid, 1);
    checkOutput("t2d_fx_h0_gnt", fxH0Gnt, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("t2e_rr_h1_rvalid", rrH1Rvalid, 1);
    checkOutput("t2e_fx_h0_rvalid", fxH0Rvalid, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_rr_err", rrErr, 0);
    checkOutput("t2_fx_err", fxErr, 0);

    // Lock: h1 waits for grant while h0 joins; fields stay on h1
    doReset();
    applyStimulus(0, 1, 0, 0);
    checkOutput("t3a_req", rrReq, 1);
    checkOutput("t3a_addr", rrAddr, 64'h2000);
    nextCycle();
    applyStimulus(1, 1, 0, 0);
    checkOutput("t3b_addr", rrAddr, 64'h2000);
    checkOutput("t3b_be", rrBe, 8'h0F);
    nextCycle();
    applyStimulus(1, 1, 0, 0);
    checkOutput("t3c_addr", rrAddr, 64'h2000);
    nextCycle();
    applyStimulus(1, 1, 1, 0);
    checkOutput("t3d_h1_gnt", rrH1Gnt, 1);
    checkOutput("t3d_h0_gnt", rrH0Gnt, 0);
    nextCycle();
    applyStimulus(1, 0, 1, 0);
    checkOutput("t3e_h0_gnt", rrH0Gnt, 1);
    checkOutput("t3e_addr", rrAddr, 64'h1000);
    nextCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("t3f_h1_rvalid", rrH1Rvalid, 1);
    checkOutput("t3f_h0_rvalid", rrH0Rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("t3g_h0_rvalid", rrH0Rvalid, 1);
    nextCycle();

    // Full FIFO blocks req_o with no same-cycle bypass
    doReset();
    applyStimulus(1, 0, 1, 0);
    checkOutput("t4a_h0_gnt", rrH0Gnt, 1);
    nextCycle();
    applyStimulus(0, 1, 1, 0);
    checkOutput("t4b_h1_gnt", rrH1Gnt, 1);
    nextCycle();
    applyStimulus(1, 0, 1, 0);
    checkOutput("t4c_full_req", rrReq, 0);
    checkOutput("t4c_full_gnt", rrH0Gnt, 0);
    nextCycle();
    applyStimulus(1, 0, 1, 1);
    checkOutput("t4d_nobypass_req", rrReq, 0);
    checkOutput("t4d_h0_rvalid", rrH0Rvalid, 1);
    nextCycle();
    applyStimulus(1, 0, 1, 1);
    checkOutput("t4e_req", rrReq, 1);
    checkOutput("t4e_h0_gnt", rrH0Gnt, 1);
    checkOutput("t4e_h1_rvalid", rrH1Rvalid, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("t4f_h0_rvalid", rrH0Rvalid, 1);
    nextCycle();

    // Unsolicited response sets sticky err_o
    applyStimulus(0, 0, 0, 1);
    checkOutput("t5_h0_rvalid", rrH0Rvalid, 0);
    checkOutput("t5_h1_rvalid", rrH1Rvalid, 0);
    checkOutput("t5_err_before", rrErr, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t5_err_set", rrErr, 1);
    nextCycle();
    nextCycle();
    checkOutput("t5_err_held", rrErr, 1);

    // Async reset with two outstanding
    doReset();
    checkOutput("t6_err_cleared", rrErr, 0);
    applyStimulus(1, 0, 1, 0);
    nextCycle();
    applyStimulus(0, 1, 1, 0);
    nextCycle();
    applyStimulus(1, 0, 1, 1);
    checkOutput("t6_pre_h0_rvalid", rrH0Rvalid, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_async_req", rrReq, 0);
    checkOutput("t6_async_h0_gnt", rrH0Gnt, 0);
    checkOutput("t6_async_h0_rvalid", rrH0Rvalid, 0);
    checkOutput("t6_async_err", rrErr, 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t6_count_cleared_req", rrReq, 1);
    nextCycle();
    applyStimulus(1, 0, 1, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("t6_one_outst_rvalid", rrH0Rvalid, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("t6_late_rvalid", rrH0Rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_late_err", rrErr, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
